// File: rtl/and_or_bist_pkg.sv
// and_or_bist_pkg: shared FSM states, LFSR constants and field widths for the AND/OR selector BIST.
package and_or_bist_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_e;
  localparam logic [7:0] LFSR_SEED = 8'h01;
  // Taps 8,6,5,4 expressed as state bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam int OPD_W = 4;
  localparam int RES_W = 4;
endpackage

// File: rtl/and_or_bist_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR operand generator with seed load and step enable.
module lfsr8
  import and_or_bist_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       load_i,
  output logic [7:0] state_o,
  output logic [7:0] next_o
);
  logic [7:0] state_q;
  assign next_o  = {state_q[6:0], ^(state_q & LFSR_TAPS)};
  assign state_o = state_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LFSR_SEED;
    else if (load_i) state_q <= LFSR_SEED;
    else if (en_i) state_q <= next_o;
  end
endmodule

// File: rtl/tt_um_and_or_bist.sv
// tt_um_and_or_bist: drives pseudo-random AND/OR vectors onto the pins and checks the selector's result.
module tt_um_and_or_bist
  import and_or_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 3
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);
  localparam int CW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
  state_e           state_q;
  logic [1:0]       start_q;
  logic             sel_q, pass_q, done_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       err_q, err_d;
  logic [7:0]       lfsr, lfsr_next;
  logic [OPD_W-1:0] a, b;
  logic [RES_W-1:0] exp_res, got_res;
  logic             rise, idle, busy, mismatch, unused_ok;
  assign a        = lfsr[3:0];
  assign b        = lfsr[7:4];
  assign exp_res  = sel_q ? (a | b) : (a & b);
  // Loopback reflects the expectation, optionally corrupted on OR checks to prove the comparator works.
  assign got_res  = ui_in[1] ? ui_in[7:4] : exp_res ^ {3'b000, ui_in[2] & sel_q};
  assign mismatch = got_res != exp_res;
  assign err_d    = err_q + 4'(err_q != 4'hF);
  assign rise     = start_q[0] & ~start_q[1];
  assign idle     = (state_q == IDLE) || (state_q == DONE);
  assign busy     = (state_q == SETTLE) || (state_q == CHECK);
  assign uo_out   = {err_q, pass_q, done_q, busy, sel_q};
  assign uio_oe   = {8{rst_n}};
  assign unused_ok = &{1'b0, uio_in, ui_in[3]};
  lfsr8 u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (ena && state_q == CHECK && sel_q),
    .load_i (ena && idle && rise),
    .state_o(lfsr),
    .next_o (lfsr_next)
  );
  assign uio_out = lfsr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= '0;
      sel_q   <= 1'b0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else if (ena) begin
      start_q <= {start_q[0], ui_in[0]};
      case (state_q)
        IDLE, DONE: if (rise) begin
          state_q <= SETTLE;
          sel_q   <= 1'b0;
          pass_q  <= 1'b1;
          done_q  <= 1'b0;
          err_q   <= '0;
          cnt_q   <= CNT_LOAD;
        end
        SETTLE: if (cnt_q == '0) state_q <= CHECK; else cnt_q <= cnt_q - CW'(1);
        CHECK: begin
          if (mismatch) begin
            pass_q <= 1'b0;
            err_q  <= err_d;
          end
          sel_q <= ~sel_q;
          cnt_q <= CNT_LOAD;
          if (sel_q && lfsr_next == LFSR_SEED) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else state_q <= SETTLE;
        end
      endcase
    end
  end
endmodule

// File: doc/tt_um_and_or_bist.md
# tt_um_and_or_bist

Built-in self-test companion for the AND/OR selector tile: the driving end of the selector's pin interface. Generates pseudo-random 4-bit operand pairs and an AND/OR select, presents them on the bidirectional pins, samples the selector's 4-bit result after a settle window, and compares it with an internally computed expectation. Reports busy/done/pass and a saturating error count on the dedicated outputs. It uses the standard TinyTapeout user-project pinout, so it can sit on a board next to the selector tile or run standalone in loopback.

## Interface
- SETTLE_CYCLES, 3: cycles a vector is held stable before the result is sampled (≥1).
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  design selected; 0 freezes FSM, LFSR and counters
- ui_in  in  8  [0] start (rising edge), [1] mode (0 loopback, 1 external), [2] inject error (loopback only), [3] unused, [7:4] result from selector
- uo_out  out  8  [0] sel (0 AND, 1 OR), [1] busy, [2] done, [3] pass, [7:4] error count
- uio_in  in  8  unused
- uio_out  out  8  [3:0] operand A, [7:4] operand B
- uio_oe  out  8  8'h00 in reset, 8'hFF otherwise

## Operation
- 8-bit Fibonacci LFSR, taps 8,6,5,4: fb = l[7]^l[5]^l[4]^l[3], next = {l[6:0], fb}. Seed 8'h01, period 255. uio_out = LFSR state directly.
- FSM states: IDLE, SETTLE, CHECK, DONE.
  - IDLE/DONE: registered start-edge detect on ui_in[0]. On a rising edge: LFSR←01, sel←0, err_cnt←0, pass←1, done←0 → SETTLE.
  - SETTLE: held SETTLE_CYCLES cycles (down-counter) → CHECK.
  - CHECK: one cycle. Sample result, compare, then advance:
    - sel=0: sel←1 → SETTLE.
    - sel=1: sel←0, LFSR steps. Next state 01 → DONE, else → SETTLE.
- Result source: mode=1 uses ui_in[7:4]. mode=0 uses the internal expectation. With inject=1 and sel=1, bit 0 of that value is inverted.
- Expected result: sel ? (A|B) : (A&B).
- On mismatch: pass←0; err_cnt increments, saturating at 15.
- busy = (state is SETTLE or CHECK). done = 1 in DONE. pass and err_cnt hold their values until the next start.
- A start edge while busy is ignored. Edge detection continues while busy, so a held-high start does not retrigger.
- ena=0: all registers hold, including the start-edge register.

## Timing
- Reset values: uo_out=8'h00, uio_out=8'h01, uio_oe=8'h00, state IDLE. Reset asserted mid-run aborts the run immediately, with no trailing check.
- Start edge sampled at edge N: busy=1 and vector 01/sel 0 valid after edge N+1.
- Each check takes SETTLE_CYCLES+1 cycles. A full run is 510 checks = 510×(SETTLE_CYCLES+1) cycles (2040 at default); done rises on the following edge.
- The vector changes only on CHECK exit. Operands stay stable for SETTLE_CYCLES+1 cycles, including the sampling cycle.
- Wrap: the LFSR returning to 01 ends the run. State 00 is unreachable.

## Structure
- Package and_or_bist_pkg: FSM state enum, LFSR_SEED (8'h01), LFSR tap mask, result/operand field widths.
- Sub-module lfsr8: enable, load-seed, 8-bit state out.
- Everything else lives in the top level: FSM, settle counter, compare, saturating counter.

## Test plan
- Reset, then release: uo_out=00, uio_out=01, uio_oe=FF after release; stays idle without a start.
- Loopback, no inject: start → first vector A=1, B=0, sel=0 for 4 cycles, then sel=1. Run completes after 2040 cycles with done=1, pass=1, err=0, uio_out back to 01.
- Loopback, inject=1: every OR check fails (255 mismatches) → pass=0, err=15 (saturated). A restart clears these to pass=1, err=0.
- External mode, bench models a correct selector with 1-cycle latency → pass=1. The bench then forces result 4'hF on every check → fails only where the expectation ≠ F, pass=0, err=15.
- Start pulse mid-run is ignored (run length unchanged). rst_n low at cycle 1000 → outputs return to reset values immediately, and a fresh start runs a full 2040 cycles.
- ena=0 for 50 cycles mid-run → outputs frozen, total run length extends by exactly 50 cycles.
